// File: rtl/dm_cache_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_cache_ctrl_if : CPU load/store and ram-side signal bundle for   |
// |                    the direct-mapped cache controller.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface dm_cache_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic [31:0]       mem_data;
    logic [31:0]       mem_addr;
    logic              mem_wr;
    logic              mem_response;
    logic [31:0]       mem_rdata;

    // Controller side: serves the CPU, drives the ram.
    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_response, mem_rdata,
        output cpu_rdata, cpu_ready, mem_data, mem_addr, mem_wr
    );

    // Environment side: CPU stimulus plus ram response.
    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_response, mem_rdata,
        input  cpu_rdata, cpu_ready, mem_data, mem_addr, mem_wr
    );
endinterface
`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_cache_ctrl : direct-mapped, write-through, one-word-per-line    |
// |                 cache controller in front of a change-detect ram.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dm_cache_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int LINES   = 8,
    parameter int INDEX_W = $clog2(LINES)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dm_cache_ctrl_if.slave    bus
);
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_SETTLE = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                req_wr_q, req_wr_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [31:0]         req_wdata_q, req_wdata_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [LINES];
    logic [31:0]         data_q [LINES];
    logic [31:0]         cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic [31:0]         mem_data_q, mem_data_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic                mem_wr_q, mem_wr_d;

    logic                line_we;
    logic [31:0]         line_wdata;
    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;

    assign idx     = req_addr_q[INDEX_W-1:0];
    assign req_tag = req_addr_q[ADDR_W-1:INDEX_W];
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            valid_q     <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            mem_data_q  <= '0;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_wr_q    <= req_wr_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            valid_q     <= valid_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            mem_data_q  <= mem_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    // Tag/data storage carries no reset; the valid bits alone gate hits.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= req_tag;
            data_q[idx] <= line_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_wr_d    = req_wr_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        valid_d     = valid_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        mem_data_d  = mem_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wr_d    = mem_wr_q;
        line_we     = 1'b0;
        line_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    req_wr_d    = bus.cpu_wr;
                    req_addr_d  = bus.cpu_addr;
                    req_wdata_d = bus.cpu_wdata;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!req_wr_q && hit) begin
                    cpu_rdata_d = data_q[idx];
                    cpu_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    mem_addr_d = 32'(req_addr_q);
                    mem_wr_d   = req_wr_q;
                    if (req_wr_q) begin
                        mem_data_d = req_wdata_q;
                        line_we    = hit;
                        line_wdata = req_wdata_q;
                    end
                    state_d = S_SETTLE;
                end
            end
            // The ram's response still reflects the previous operation here.
            S_SETTLE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_response) begin
                    if (!req_wr_q) begin
                        cpu_rdata_d  = bus.mem_rdata;
                        line_we      = 1'b1;
                        line_wdata   = bus.mem_rdata;
                        valid_d[idx] = 1'b1;
                    end
                    cpu_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wr    = mem_wr_q;
endmodule
`default_nettype wire
